store_write_buffer: RTL
=======================

Name: store_write_buffer

Overview:
- FIFO write buffer between the write-through data cache's memory-side port and the 2-to-1 data bridge.
- Stores are retired to the cache at one per cycle. Stores drain to memory in order, in the background.
- Reads are ordered behind all buffered stores, so a read never returns stale data.
- Both sides use the SRAM-like req/addr_ok/data_ok protocol.

Parameters:
- DEPTH, 4, number of store entries; power of two, minimum 2.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  in  1  clock
- resetn  in  1  reset; asynchronous, active-low
- cpu_data_req  in  1  upstream request
- cpu_data_wr  in  1  1 = write, 0 = read
- cpu_data_size  in  2  00 = byte, 01 = half, 10 = word
- cpu_data_addr  in  32  physical address
- cpu_data_wdata  in  32  store data
- cpu_data_rdata  out  32  load data
- cpu_data_addr_ok  out  1  request accepted
- cpu_data_data_ok  out  1  transaction complete
- mem_data_req  out  1  downstream request
- mem_data_wr  out  1  downstream write/read select
- mem_data_size  out  2  downstream size
- mem_data_addr  out  32  downstream address
- mem_data_wdata  out  32  downstream store data
- mem_data_rdata  in  32  downstream load data
- mem_data_addr_ok  in  1  downstream accept
- mem_data_data_ok  in  1  downstream complete
- buf_empty  out  1  no buffered or in-flight store

Behaviour:
- Reset (asynchronous, resetn=0):
  - Pointers and count cleared; FSM to IDLE; buffered entries discarded.
  - Outputs: all *_req, *_ok, mem_data_wr = 0; rdata/addr/wdata/size = 0; buf_empty = 1.
- Entry format: {addr[31:0], size[1:0], wdata[31:0]}.
- Upstream write:
  - cpu_data_addr_ok = 1 in the same cycle when count < DEPTH and no read is outstanding; entry pushed on that edge.
  - cpu_data_data_ok is registered: exactly one cycle after acceptance, for one cycle.
  - When count == DEPTH, addr_ok = 0 even if a pop occurs that cycle. No full-cycle bypass.
- Upstream read:
  - Accepted (addr_ok = 1) only in IDLE with count == 0 and no registered write data_ok pending that cycle.
  - On acceptance, addr and size are latched and the FSM goes to RD_REQ.
  - While a read is outstanding (RD_REQ/RD_RESP), all upstream requests see addr_ok = 0.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP.
  - IDLE -> WR_REQ when count > 0. Drain has priority over an arriving read.
  - IDLE -> RD_REQ on read accept.
  - WR_REQ: mem_data_req = 1, mem_data_wr = 1, head entry driven. On mem_data_addr_ok -> WR_RESP.
  - WR_RESP: mem_data_req = 0. On mem_data_data_ok, pop head; go to WR_REQ if count > 1 after the pop is accounted, else IDLE.
  - RD_REQ: mem_data_req = 1, mem_data_wr = 0, latched addr/size. On mem_data_addr_ok -> RD_RESP.
  - RD_RESP: on mem_data_data_ok, cpu_data_data_ok = 1 and cpu_data_rdata = mem_data_rdata (combinational pass-through, same cycle) -> IDLE.
- Downstream signals stay stable while mem_data_req = 1 and addr_ok = 0.
- Push and pop in the same cycle: count unchanged; pointers wrap modulo DEPTH.
- buf_empty = (count == 0) && FSM not in WR_REQ/WR_RESP.
- Minimum latencies:
  - Store: upstream accept at cycle 0 -> mem_data_req at cycle 1 (empty buffer).
  - Load: accept at cycle 0 -> mem_data_req at cycle 1 -> data returned in the cycle of mem_data_data_ok.

Optional Feature:
- Macro: STORE_WB_READ_BYPASS_EN.
- Defined: a read is also accepted in IDLE with count > 0 when no valid entry matches addr[31:2] (word compare across all valid entries). The read is issued ahead of the remaining stores. A matching entry blocks the read until the buffer is empty.
- Undefined: reads wait for count == 0; no compare logic is built.

Decomposition:
- Shared package mem_if_pkg:
  - Size constants SIZE_BYTE / SIZE_HALF / SIZE_WORD.
  - wbuf_entry_t struct.
  - wbuf_state_t enum of the five FSM states.
- One natural sub-module: wbuf_fifo. It holds the storage array, head/tail pointers, count and full/empty flags, with a combinational head read. It also has an address-match vector output, used only under STORE_WB_READ_BYPASS_EN.

Test Plan:
- Single store to 0x1FC0_0100, word, 0xDEADBEEF, buffer empty, memory accepts immediately:
  - Required: addr_ok at cycle 0, cpu data_ok at cycle 1, mem_data_req at cycle 1 with identical addr/data.
  - Required: buf_empty returns to 1 after mem data_ok.
- Five back-to-back stores with mem_data_addr_ok held 0 (DEPTH = 4):
  - Required: first four accepted; fifth sees addr_ok = 0 until the first mem data_ok.
  - Required: memory receives all five in order.
- Two stores, then a load to 0x1FC0_0100:
  - Required: load addr_ok stays low until both stores complete; memory sees the load after the second store.
  - Required: cpu rdata equals mem rdata 0x12345678 in the mem data_ok cycle.
- With STORE_WB_READ_BYPASS_EN defined:
  - Load to 0x200 while a store to 0x100 is buffered -> load issued before the store.
  - Load to 0x102 (same word as 0x100) -> load waits for drain.
- Assert resetn = 0 mid-drain with 3 entries buffered:
  - Required: outputs clear asynchronously; count = 0; no further mem_data_req after release.
- Wrap-around: 12 stores with random mem latency 0–3 cycles:
  - Required: in-order drain, no lost or duplicated entry; scoreboard matches.

Source files
------------

// File: rtl/mem_if_pkg.sv
// Shared definitions for the data-side memory interface and the store write buffer.
//   SIZE_*        : encodings for the req size field
//   wbuf_entry_t  : one buffered store {addr, size, wdata}
//   wbuf_state_t  : drain / read sequencing states of store_write_buffer
package mem_if_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   typedef struct packed {
      logic [31:0] addr;
      logic [1:0]  size;
      logic [31:0] wdata;
   } wbuf_entry_t;

   typedef enum logic [2:0] {
      StIdle,
      StWrReq,
      StWrResp,
      StRdReq,
      StRdResp
   } wbuf_state_t;

endpackage

// File: rtl/wbuf_fifo.sv
// Storage for the store write buffer: circular array with head/tail pointers and an
// occupancy count. The head entry is read combinationally.
// Optional macro STORE_WB_READ_BYPASS_EN builds a word-address compare of cmp_addr_i
// against every valid entry; without it match_o is tied to zero.
// Ports:
//   clk, resetn           clock, asynchronous active-low reset
//   push_i, push_data_i   enqueue at tail (caller guarantees not full)
//   pop_i                 dequeue head (caller guarantees not empty)
//   head_o                current head entry
//   count_o, full_o, empty_o occupancy
//   cmp_addr_i, match_o   per-slot word-address match against valid entries
module wbuf_fifo
   import mem_if_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              push_i,
   input  wbuf_entry_t       push_data_i,
   input  logic              pop_i,
   output wbuf_entry_t       head_o,
   output logic [PTR_W:0]    count_o,
   output logic              full_o,
   output logic              empty_o,
   input  logic [31:0]       cmp_addr_i,
   output logic [DEPTH-1:0]  match_o
);

   localparam logic [PTR_W-1:0] PtrOne  = PTR_W'(1);
   localparam logic [PTR_W:0]   CntOne  = (PTR_W + 1)'(1);
   localparam logic [PTR_W:0]   CntFull = (PTR_W + 1)'(DEPTH);

   wbuf_entry_t      mem_q [DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [PTR_W:0]   count_q, count_d;

   // Power-of-two depth: pointers wrap by natural overflow.
   always_comb begin
      head_d  = pop_i  ? head_q + PtrOne : head_q;
      tail_d  = push_i ? tail_q + PtrOne : tail_q;
      count_d = count_q;
      unique case ({push_i, pop_i})
         2'b10:   count_d = count_q + CntOne;
         2'b01:   count_d = count_q - CntOne;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Payload needs no reset; validity comes from the pointers and count.
   always_ff @(posedge clk) begin
      if (push_i) begin
         mem_q[tail_q] <= push_data_i;
      end
   end

   assign head_o  = mem_q[head_q];
   assign count_o = count_q;
   assign full_o  = (count_q == CntFull);
   assign empty_o = (count_q == '0);

`ifdef STORE_WB_READ_BYPASS_EN
   always_comb begin
      logic [PTR_W-1:0] rel;
      match_o = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         // Slot i is valid when its distance from head is below the count.
         rel = PTR_W'(i) - head_q;
         match_o[i] = ({1'b0, rel} < count_q) && (mem_q[i].addr[31:2] == cmp_addr_i[31:2]);
      end
   end
`else
   logic unused_cmp_addr;
   assign unused_cmp_addr = ^cmp_addr_i;
   assign match_o = '0;
`endif

endmodule

// File: rtl/store_write_buffer.sv
// Write buffer between the write-through D-cache memory port and the data bridge.
// Stores are accepted one per cycle into a FIFO and drained to memory in order in
// the background; reads are held until all buffered stores have completed, so a read
// never sees stale memory.
// Optional macro STORE_WB_READ_BYPASS_EN: a read whose word address matches no buffered
// store may be issued ahead of the remaining stores.
// Ports (SRAM-like req/addr_ok/data_ok on both sides):
//   clk, resetn              clock, asynchronous active-low reset
//   cpu_data_*               upstream request/response from the cache
//   mem_data_*               downstream request/response to the bridge
//   buf_empty                no buffered and no in-flight store
module store_write_buffer
   import mem_if_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        cpu_data_req,
   input  logic        cpu_data_wr,
   input  logic [1:0]  cpu_data_size,
   input  logic [31:0] cpu_data_addr,
   input  logic [31:0] cpu_data_wdata,
   output logic [31:0] cpu_data_rdata,
   output logic        cpu_data_addr_ok,
   output logic        cpu_data_data_ok,
   output logic        mem_data_req,
   output logic        mem_data_wr,
   output logic [1:0]  mem_data_size,
   output logic [31:0] mem_data_addr,
   output logic [31:0] mem_data_wdata,
   input  logic [31:0] mem_data_rdata,
   input  logic        mem_data_addr_ok,
   input  logic        mem_data_data_ok,
   output logic        buf_empty
);

   localparam int unsigned     PTR_W  = $clog2(DEPTH);
   localparam logic [PTR_W:0]  CntOne = (PTR_W + 1)'(1);

   wbuf_state_t       state_q, state_d;
   logic [31:0]       rd_addr_q, rd_addr_d;
   logic [1:0]        rd_size_q, rd_size_d;
   logic              wr_ok_q, wr_ok_d;

   wbuf_entry_t       head;
   logic [PTR_W:0]    count;
   logic              full, empty;
   logic [DEPTH-1:0]  addr_match;
   logic              push, pop, wr_accept, rd_accept, rd_busy, rd_try, rd_done;

   wbuf_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .resetn      (resetn),
      .push_i      (push),
      .push_data_i ('{addr: cpu_data_addr, size: cpu_data_size, wdata: cpu_data_wdata}),
      .pop_i       (pop),
      .head_o      (head),
      .count_o     (count),
      .full_o      (full),
      .empty_o     (empty),
      .cmp_addr_i  (cpu_data_addr),
      .match_o     (addr_match)
   );

   assign rd_busy   = (state_q == StRdReq) || (state_q == StRdResp);
   // No full-cycle bypass: a pop in the same cycle does not free a slot for a push.
   assign wr_accept = cpu_data_req && cpu_data_wr && !full && !rd_busy;
   assign rd_try    = cpu_data_req && !cpu_data_wr && (state_q == StIdle) && !wr_ok_q;

`ifdef STORE_WB_READ_BYPASS_EN
   assign rd_accept = rd_try && (empty || (addr_match == '0));
`else
   logic unused_match;
   assign unused_match = |addr_match;
   assign rd_accept    = rd_try && empty;
`endif

   assign push = wr_accept;
   assign pop  = (state_q == StWrResp) && mem_data_data_ok;

   assign cpu_data_addr_ok = wr_accept || rd_accept;
   assign buf_empty = empty && (state_q != StWrReq) && (state_q != StWrResp);

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= StIdle;
         rd_addr_q <= '0;
         rd_size_q <= '0;
         wr_ok_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         rd_addr_q <= rd_addr_d;
         rd_size_q <= rd_size_d;
         wr_ok_q   <= wr_ok_d;
      end
   end

   // Next state
   always_comb begin
      state_d   = state_q;
      rd_addr_d = rd_addr_q;
      rd_size_d = rd_size_q;
      wr_ok_d   = wr_accept;
      if (rd_accept) begin
         rd_addr_d = cpu_data_addr;
         rd_size_d = cpu_data_size;
      end
      unique case (state_q)
         StIdle: begin
            // Looking ahead at the push gives a one-cycle store-to-mem_req latency.
            if (rd_accept) begin
               state_d = StRdReq;
            end else if (!empty || push) begin
               state_d = StWrReq;
            end
         end
         StWrReq: begin
            if (mem_data_addr_ok) begin
               state_d = StWrResp;
            end
         end
         StWrResp: begin
            if (mem_data_data_ok) begin
               state_d = ((count > CntOne) || push) ? StWrReq : StIdle;
            end
         end
         StRdReq: begin
            if (mem_data_addr_ok) begin
               state_d = StRdResp;
            end
         end
         StRdResp: begin
            if (mem_data_data_ok) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs
   always_comb begin
      mem_data_req   = 1'b0;
      mem_data_wr    = 1'b0;
      mem_data_size  = '0;
      mem_data_addr  = '0;
      mem_data_wdata = '0;
      cpu_data_rdata = '0;
      rd_done        = 1'b0;
      unique case (state_q)
         StWrReq: begin
            mem_data_req   = 1'b1;
            mem_data_wr    = 1'b1;
            mem_data_size  = head.size;
            mem_data_addr  = head.addr;
            mem_data_wdata = head.wdata;
         end
         StRdReq: begin
            mem_data_req  = 1'b1;
            mem_data_size = rd_size_q;
            mem_data_addr = rd_addr_q;
         end
         StRdResp: begin
            if (mem_data_data_ok) begin
               rd_done        = 1'b1;
               cpu_data_rdata = mem_data_rdata;
            end
         end
         default: ;
      endcase
   end

   assign cpu_data_data_ok = wr_ok_q || rd_done;

endmodule
